// File: rtl/mfp_adc_max10_responder.sv
// Behavioural stand-in for the MAX10 modular ADC command/response interface:
// accepts one command at a time, waits a fixed conversion latency, then returns a synthetic sample.
module mfp_adc_max10_responder #(
  parameter int unsigned CONV_CYCLES = 8,
  parameter int unsigned MAX_CHANNEL = 17,
  parameter logic [11:0] DATA_SEED   = 12'h000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ADC_C_Valid,
  input  logic [4:0]  ADC_C_Channel,
  input  logic        ADC_C_SOP,
  input  logic        ADC_C_EOP,
  output logic        ADC_C_Ready,
  output logic        ADC_R_Valid,
  output logic [4:0]  ADC_R_Channel,
  output logic [11:0] ADC_R_Data,
  output logic        ADC_R_SOP,
  output logic        ADC_R_EOP,
  output logic        ADC_Busy,
  output logic [15:0] ADC_Conv_Count
);

  localparam int unsigned CH_W   = 5;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CC_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ch;
  logic              r_sop;
  logic              r_eop;
  logic [DATA_W-1:0] r_sample;
  logic              r_c_ready;
  logic              r_r_valid;
  logic [CH_W-1:0]   r_r_ch;
  logic [DATA_W-1:0] r_r_data;
  logic              r_r_sop;
  logic              r_r_eop;
  logic              r_busy;
  logic [CC_W-1:0]   r_conv_count;

  logic              w_accept;
  logic              w_out_of_range;
  logic [DATA_W-1:0] w_sample_data;

  assign w_accept       = ADC_C_Valid & r_c_ready;
  assign w_out_of_range = 32'(r_ch) > MAX_CHANNEL;
  // Channel placed at bit 7 so each channel owns a distinct 128-code window.
  assign w_sample_data  = w_out_of_range ? {DATA_W{1'b1}}
                                         : ({r_ch, 7'b0} + r_sample);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_sample     <= DATA_SEED;
      r_c_ready    <= 1'b0;
      r_r_valid    <= 1'b0;
      r_r_ch       <= '0;
      r_r_data     <= '0;
      r_r_sop      <= 1'b0;
      r_r_eop      <= 1'b0;
      r_busy       <= 1'b0;
      r_conv_count <= '0;
    end else begin
      // Response fields are zero except during the single RESPOND cycle.
      r_r_valid <= 1'b0;
      r_r_ch    <= '0;
      r_r_data  <= '0;
      r_r_sop   <= 1'b0;
      r_r_eop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_c_ready <= ~w_accept;
          r_busy    <= w_accept;
          if (w_accept) begin
            r_ch    <= ADC_C_Channel;
            r_sop   <= ADC_C_SOP;
            r_eop   <= ADC_C_EOP;
            r_cnt   <= CNT_LOAD;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (r_cnt == '0) begin
            r_state   <= S_RESPOND;
            r_r_valid <= 1'b1;
            r_r_ch    <= r_ch;
            r_r_data  <= w_sample_data;
            r_r_sop   <= r_sop;
            r_r_eop   <= r_eop;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESPOND: begin
          r_state      <= S_IDLE;
          r_c_ready    <= 1'b1;
          r_busy       <= 1'b0;
          r_sample     <= r_sample + DATA_W'(1);
          r_conv_count <= r_conv_count + CC_W'(1);
        end
        default: begin
          r_state   <= S_IDLE;
          r_c_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign ADC_C_Ready    = r_c_ready;
  assign ADC_R_Valid    = r_r_valid;
  assign ADC_R_Channel  = r_r_ch;
  assign ADC_R_Data     = r_r_data;
  assign ADC_R_SOP      = r_r_sop;
  assign ADC_R_EOP      = r_r_eop;
  assign ADC_Busy       = r_busy;
  assign ADC_Conv_Count = r_conv_count;

endmodule

// File: tb/tb_mfp_adc_max10_responder.sv
// Directed bench for mfp_adc_max10_responder: three instances cover the default
// configuration, a near-wrap data seed and the minimum conversion latency.
module tb_mfp_adc_max10_responder;

  logic        CLK;
  logic        rst_n;
  logic        c_valid [3];
  logic [4:0]  c_ch    [3];
  logic        c_sop   [3];
  logic        c_eop   [3];
  logic        c_ready [3];
  logic        r_valid [3];
  logic [4:0]  r_ch    [3];
  logic [11:0] r_data  [3];
  logic        r_sop   [3];
  logic        r_eop   [3];
  logic        busy    [3];
  logic [15:0] ccount  [3];

  int errors = 0;
  int checks = 0;

  mfp_adc_max10_responder #(.CONV_CYCLES(8), .MAX_CHANNEL(17), .DATA_SEED(12'h000)) u_dut0 (
    .CLK(CLK), .RESETn(rst_n),
    .ADC_C_Valid(c_valid[0]), .ADC_C_Channel(c_ch[0]), .ADC_C_SOP(c_sop[0]), .ADC_C_EOP(c_eop[0]),
    .ADC_C_Ready(c_ready[0]), .ADC_R_Valid(r_valid[0]), .ADC_R_Channel(r_ch[0]), .ADC_R_Data(r_data[0]),
    .ADC_R_SOP(r_sop[0]), .ADC_R_EOP(r_eop[0]), .ADC_Busy(busy[0]), .ADC_Conv_Count(ccount[0]));

  mfp_adc_max10_responder #(.CONV_CYCLES(8), .MAX_CHANNEL(17), .DATA_SEED(12'hFFE)) u_dut1 (
    .CLK(CLK), .RESETn(rst_n),
    .ADC_C_Valid(c_valid[1]), .ADC_C_Channel(c_ch[1]), .ADC_C_SOP(c_sop[1]), .ADC_C_EOP(c_eop[1]),
    .ADC_C_Ready(c_ready[1]), .ADC_R_Valid(r_valid[1]), .ADC_R_Channel(r_ch[1]), .ADC_R_Data(r_data[1]),
    .ADC_R_SOP(r_sop[1]), .ADC_R_EOP(r_eop[1]), .ADC_Busy(busy[1]), .ADC_Conv_Count(ccount[1]));

  mfp_adc_max10_responder #(.CONV_CYCLES(1), .MAX_CHANNEL(17), .DATA_SEED(12'h000)) u_dut2 (
    .CLK(CLK), .RESETn(rst_n),
    .ADC_C_Valid(c_valid[2]), .ADC_C_Channel(c_ch[2]), .ADC_C_SOP(c_sop[2]), .ADC_C_EOP(c_eop[2]),
    .ADC_C_Ready(c_ready[2]), .ADC_R_Valid(r_valid[2]), .ADC_R_Channel(r_ch[2]), .ADC_R_Data(r_data[2]),
    .ADC_R_SOP(r_sop[2]), .ADC_R_EOP(r_eop[2]), .ADC_Busy(busy[2]), .ADC_Conv_Count(ccount[2]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command on a CONV_CYCLES=8 instance, checked cycle by cycle through its response.
  task automatic cmd(input int d, input logic [4:0] ch, input logic sop, input logic eop,
                     input logic [11:0] exp_data, input logic [15:0] exp_cnt);
    logic seen;
    @(negedge CLK);
    chk("ready_before_cmd", 32'(c_ready[d]), 32'd1);
    c_valid[d] = 1'b1; c_ch[d] = ch; c_sop[d] = sop; c_eop[d] = eop;
    @(posedge CLK); #1;
    c_valid[d] = 1'b0; c_ch[d] = 5'h1F; c_sop[d] = ~sop; c_eop[d] = ~eop;
    chk("busy_convert", 32'(busy[d]), 32'd1);
    chk("ready_convert", 32'(c_ready[d]), 32'd0);
    seen = 1'b0;
    repeat (7) begin
      @(posedge CLK); #1;
      if (r_valid[d]) seen = 1'b1;
    end
    chk("no_early_rvalid", 32'(seen), 32'd0);
    @(posedge CLK); #1;
    chk("rvalid_pulse", 32'(r_valid[d]), 32'd1);
    chk("r_channel", 32'(r_ch[d]), 32'(ch));
    chk("r_data", 32'(r_data[d]), 32'(exp_data));
    chk("r_sop", 32'(r_sop[d]), 32'(sop));
    chk("r_eop", 32'(r_eop[d]), 32'(eop));
    chk("ready_respond", 32'(c_ready[d]), 32'd0);
    @(posedge CLK); #1;
    chk("rvalid_drop", 32'(r_valid[d]), 32'd0);
    chk("r_data_idle", 32'(r_data[d]), 32'd0);
    chk("r_channel_idle", 32'(r_ch[d]), 32'd0);
    chk("ready_after", 32'(c_ready[d]), 32'd1);
    chk("busy_after", 32'(busy[d]), 32'd0);
    chk("conv_count", 32'(ccount[d]), 32'(exp_cnt));
  endtask

  initial begin
    logic [11:0] pdata [8];
    int          pcyc  [8];
    int          acyc  [8];
    int          npulse;
    int          nacc;
    logic        any_valid;
    logic        both_high;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_valid[i] = 1'b0; c_ch[i] = '0; c_sop[i] = 1'b0; c_eop[i] = 1'b0;
    end

    // Reset state, including Ready held low across an edge while in reset
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(c_ready[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_rvalid", 32'(r_valid[i]), 32'd0);
      chk("rst_count", 32'(ccount[i]), 32'd0);
    end
    @(posedge CLK); #1;
    chk("rst_ready_held", 32'(c_ready[0]), 32'd0);
    @(negedge CLK); #2;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) chk("ready_post_rst", 32'(c_ready[i]), 32'd1);

    // Basic command: ch3 -> 3<<7 = 0x180
    cmd(0, 5'd3, 1'b1, 1'b1, 12'h180, 16'd1);

    // Reset during CONVERT aborts the command
    @(negedge CLK);
    c_valid[0] = 1'b1; c_ch[0] = 5'd7; c_sop[0] = 1'b1; c_eop[0] = 1'b1;
    @(posedge CLK); #1;
    c_valid[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_ready", 32'(c_ready[0]), 32'd0);
    chk("abort_count", 32'(ccount[0]), 32'd0);
    @(negedge CLK); #2;
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (r_valid[0]) any_valid = 1'b1;
    end
    chk("abort_no_response", 32'(any_valid), 32'd0);
    chk("abort_ready_after", 32'(c_ready[0]), 32'd1);
    chk("abort_busy_after", 32'(busy[0]), 32'd0);
    chk("abort_count_after", 32'(ccount[0]), 32'd0);

    // Out-of-range channel answers 0xFFF but still consumes a sample
    cmd(0, 5'd20, 1'b0, 1'b1, 12'hFFF, 16'd1);
    cmd(0, 5'd0, 1'b1, 1'b0, 12'h001, 16'd2);

    // Valid held high for 30 cycles on ch0
    @(negedge CLK);
    c_valid[0] = 1'b1; c_ch[0] = 5'd0; c_sop[0] = 1'b1; c_eop[0] = 1'b1;
    npulse = 0; nacc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (c_ready[0] && nacc < 8) begin acyc[nacc] = cyc; nacc++; end
      @(posedge CLK); #1;
      if (r_valid[0] && npulse < 8) begin pdata[npulse] = r_data[0]; npulse++; end
    end
    c_valid[0] = 1'b0;
    chk("held_accepts", 32'(nacc), 32'd3);
    chk("held_acc1_cycle", 32'(acyc[1]), 32'd10);
    chk("held_acc2_cycle", 32'(acyc[2]), 32'd20);
    chk("held_pulses", 32'(npulse), 32'd3);
    chk("held_data0", 32'(pdata[0]), 32'h002);
    chk("held_data1", 32'(pdata[1]), 32'h003);
    chk("held_data2", 32'(pdata[2]), 32'h004);
    chk("held_count", 32'(ccount[0]), 32'd5);

    // Seed 0xFFE wraps after two samples
    cmd(1, 5'd0, 1'b1, 1'b1, 12'hFFE, 16'd1);
    cmd(1, 5'd0, 1'b0, 1'b0, 12'hFFF, 16'd2);
    cmd(1, 5'd0, 1'b1, 1'b0, 12'h000, 16'd3);

    // CONV_CYCLES=1 back-to-back: ch5 -> 0x280 base
    @(negedge CLK);
    c_valid[2] = 1'b1; c_ch[2] = 5'd5; c_sop[2] = 1'b1; c_eop[2] = 1'b1;
    npulse = 0; both_high = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge CLK); #1;
      if (r_valid[2] && c_ready[2]) both_high = 1'b1;
      if (r_valid[2] && npulse < 8) begin
        pcyc[npulse] = cyc; pdata[npulse] = r_data[2]; npulse++;
      end
    end
    c_valid[2] = 1'b0;
    chk("fast_pulses", 32'(npulse), 32'd4);
    chk("fast_cyc0", 32'(pcyc[0]), 32'd1);
    chk("fast_cyc1", 32'(pcyc[1]), 32'd4);
    chk("fast_cyc2", 32'(pcyc[2]), 32'd7);
    chk("fast_cyc3", 32'(pcyc[3]), 32'd10);
    chk("fast_data0", 32'(pdata[0]), 32'h280);
    chk("fast_data3", 32'(pdata[3]), 32'h283);
    chk("fast_ready_rvalid_overlap", 32'(both_high), 32'd0);
    chk("fast_count", 32'(ccount[2]), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
